imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Sequences programming of the 128x32 instruction memory before a pipeline run.
- Assembles a byte stream from the UART receiver into 32-bit instruction words and issues single-cycle write strobes at sequential addresses from 0.
- Terminates on the HALT word (opcode 6'b111111), or flags an error on overflow or inter-byte timeout.
- Sits between the debug-unit UART RX and the instruction memory's write port; `o_done` releases the pipeline to fetch.

Parameters:
- DATA_WIDTH, 32: instruction word width; must equal 4*BYTE_WIDTH.
- BYTE_WIDTH, 8: width of the incoming byte stream.
- DATA_DEPTH, 128: instruction memory depth in words.
- ADDR_WIDTH, 7: address width, log2(DATA_DEPTH).
- TIMEOUT_CYCLES, 1_000_000: maximum idle cycles allowed between bytes of a partially received word.

Ports:
- i_clk  in  1  system clock (100 MHz).
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  load request pulse.
- i_rx_data  in  BYTE_WIDTH  received byte.
- i_rx_valid  in  1  one-cycle strobe; `i_rx_data` is valid.
- o_mem_we  out  1  instruction memory write enable, one-cycle pulse.
- o_mem_addr  out  ADDR_WIDTH  write address.
- o_mem_wdata  out  DATA_WIDTH  write data.
- o_loading  out  1  high while in RECV.
- o_done  out  1  high while in DONE.
- o_error  out  1  high while in ERROR.
- o_word_count  out  ADDR_WIDTH+1  number of words written in the current load.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high (`i_reset`), sampled on the posedge of i_clk.
- Reset values: state=IDLE; all outputs 0; byte index=0; write pointer=0; timeout counter=0.
- Reset wins over every other input in the same cycle. Reset mid-load abandons the load; words already written stay in memory.

States:
- IDLE:
  - `i_start` -> RECV; clear write pointer, byte index, word count and timeout counter.
  - `i_rx_valid` is ignored.
- RECV:
  - Each `i_rx_valid` shifts `i_rx_data` into the assembly register, most significant byte first.
  - The first byte lands in bits [31:24]; byte index increments, mod 4.
- Fourth byte accepted (byte index == 3 and `i_rx_valid`), on that edge:
  - o_mem_wdata <= {assembly[23:0], i_rx_data}.
  - o_mem_addr <= write pointer.
  - o_mem_we <= 1 for exactly one cycle (write visible the cycle after the 4th byte).
  - Write pointer and o_word_count increment; byte index <= 0.
- Termination on that same edge:
  - If assembled bits [31:26] == 6'b111111 (HALT): state -> DONE. The HALT word is still written.
  - Else if write pointer == DATA_DEPTH-1: state -> ERROR (overflow). The word at DATA_DEPTH-1 is still written.
  - Else: stay in RECV.
- Back-to-back bytes: a byte arriving in the cycle `o_mem_we` is high is accepted normally as byte 0 of the next word. There is no stall and no byte loss at full rate (one byte per cycle).
- Timeout:
  - The counter runs only in RECV with byte index != 0.
  - It clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1 with no byte: state -> ERROR; no write is issued for the partial word.
- `i_start` in RECV is ignored.
- DONE and ERROR:
  - Level outputs held; `i_rx_valid` ignored; `o_mem_we` stays 0.
  - `i_start` -> RECV with the same clears as from IDLE. `o_done`/`o_error` drop on that edge.
- Combined flags: o_loading, o_done and o_error are mutually exclusive and registered from state. o_word_count holds its final value in DONE/ERROR until the next start.
- Write pointer wrap: the pointer never wraps. Overflow always terminates in ERROR before the address would wrap to 0.

Test Plan:
- Normal load:
  - Stimulus: reset, `i_start`, then bytes 8C 01 00 01 -> `o_mem_we` pulse with addr 0, data 0x8C010001.
  - Continue with 8C 02 00 02, then 80 00 00 00 -> writes to addr 1 and addr 2.
  - Then FC 00 00 00 -> write 0xFC000000 at addr 3; next cycle o_done=1, o_loading=0, o_word_count=4.
- Back-to-back bytes: 8 bytes on consecutive cycles -> two write pulses exactly 4 cycles apart, addresses 0 and 1, correct data.
- Overflow: 128 non-HALT words (data = address) -> 128 write pulses for addr 0..127, then o_error=1, o_word_count=128; a further byte produces no write.
- Timeout (TIMEOUT_CYCLES=16 in bench): bytes AA BB then silence -> o_error=1 after 16 idle cycles; `o_mem_we` never asserted.
- Restart and idle filtering:
  - Bytes presented in IDLE -> no write.
  - `i_start` in DONE -> o_done=0, next word written at addr 0, o_word_count restarts from 0.
- Reset mid-load: `i_reset` after 2 bytes of word 1 -> all outputs 0, state IDLE; a new start loads from addr 0, byte 0 as MSB.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a UART byte stream (MSB first) into
// instruction words and writes them at sequential addresses from 0.
// Stops on a HALT word, on overflow of the memory, or on an inter-byte timeout.
module imem_loader #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned DATA_DEPTH     = 128,
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [BYTE_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_loading,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH:0]   o_word_count
);

    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
    localparam int unsigned ASM_W          = DATA_WIDTH - BYTE_WIDTH;
    localparam int unsigned TO_W           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned OPC_W          = 6;

    localparam logic [OPC_W-1:0] HALT_OPC = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Only the lower bytes need holding; the newest byte comes straight from the input.
    logic [ASM_W-1:0]      asm_q;
    logic [IDX_W-1:0]      idx_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [TO_W-1:0]       to_cnt_q;

    logic loading_d;
    logic done_d;
    logic error_d;

    logic                  start_c;
    logic                  accept_c;
    logic                  word_c;
    logic                  halt_c;
    logic                  last_c;
    logic                  timeout_c;
    logic [DATA_WIDTH-1:0] word_data_c;

    assign start_c     = i_start && (state_q != RECV);
    assign accept_c    = (state_q == RECV) && i_rx_valid;
    assign word_c      = accept_c && (idx_q == LAST_IDX);
    assign word_data_c = {asm_q, i_rx_data};
    assign halt_c      = (word_data_c[DATA_WIDTH-1 -: OPC_W] == HALT_OPC);
    assign last_c      = (ptr_q == LAST_ADDR);
    assign timeout_c   = (state_q == RECV) && !i_rx_valid && (idx_q != '0)
                         && (to_cnt_q == TO_LIMIT);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = RECV;
            end
            RECV: begin
                if (word_c) begin
                    if (halt_c)      state_d = DONE;
                    else if (last_c) state_d = ERROR;
                end else if (timeout_c) begin
                    state_d = ERROR;
                end
            end
            DONE, ERROR: begin
                if (i_start) state_d = RECV;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags follow the state being entered so they line up with it
    always_comb begin
        loading_d = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        case (state_d)
            RECV:    loading_d = 1'b1;
            DONE:    done_d    = 1'b1;
            ERROR:   error_d   = 1'b1;
            default: ;
        endcase
    end

    // Registered status flags and write strobe
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_loading <= 1'b0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
            o_mem_we  <= 1'b0;
        end else begin
            o_loading <= loading_d;
            o_done    <= done_d;
            o_error   <= error_d;
            o_mem_we  <= word_c;
        end
    end

    // Byte assembly, write pointer, word count and inter-byte timeout
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            asm_q        <= '0;
            idx_q        <= '0;
            ptr_q        <= '0;
            to_cnt_q     <= '0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_word_count <= '0;
        end else if (start_c) begin
            idx_q        <= '0;
            ptr_q        <= '0;
            to_cnt_q     <= '0;
            o_word_count <= '0;
        end else if (accept_c) begin
            asm_q    <= ASM_W'({asm_q, i_rx_data});
            to_cnt_q <= '0;
            if (word_c) begin
                idx_q        <= '0;
                o_mem_addr   <= ptr_q;
                o_mem_wdata  <= word_data_c;
                o_word_count <= o_word_count + (ADDR_WIDTH + 1)'(1);
                // The last address ends the load, so the pointer is never wrapped
                if (!last_c) ptr_q <= ptr_q + ADDR_WIDTH'(1);
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end else if ((state_q == RECV) && (idx_q != '0) && !timeout_c) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios plus random byte traffic, checked
// every cycle against a word/queue level model of the loader.
module tb_imem_loader;

    localparam int unsigned TO_CYC = 16;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_mem_we;
    logic [6:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_loading;
    logic        o_done;
    logic        o_error;
    logic [7:0]  o_word_count;

    imem_loader #(
        .DATA_WIDTH    (32),
        .BYTE_WIDTH    (8),
        .DATA_DEPTH    (128),
        .ADDR_WIDTH    (7),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_loading   (o_loading),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_word_count(o_word_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Model: 0 idle, 1 loading, 2 done, 3 error
    int          m_phase;
    logic [7:0]  m_buf[$];
    int          m_count;
    int          m_idle;
    logic        exp_we;
    logic [6:0]  exp_addr;
    logic [31:0] exp_wdata;

    int total;
    int bad;
    int we_seen;

    initial begin
        m_phase   = 0;
        m_count   = 0;
        m_idle    = 0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
    end

    // Model advances on each clock edge from the inputs held across it
    always @(posedge i_clk) begin
        logic [31:0] w;
        exp_we = 1'b0;
        if (i_reset) begin
            m_phase   = 0;
            m_buf.delete();
            m_count   = 0;
            m_idle    = 0;
            exp_addr  = '0;
            exp_wdata = '0;
        end else if (m_phase != 1) begin
            if (i_start) begin
                m_phase = 1;
                m_buf.delete();
                m_count = 0;
                m_idle  = 0;
            end
        end else if (i_rx_valid) begin
            m_buf.push_back(i_rx_data);
            m_idle = 0;
            if (m_buf.size() == 4) begin
                w         = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
                exp_we    = 1'b1;
                exp_addr  = 7'(m_count);
                exp_wdata = w;
                m_count   = m_count + 1;
                m_buf.delete();
                if (w[31:26] == 6'h3F)  m_phase = 2;
                else if (m_count == 128) m_phase = 3;
            end
        end else if (m_buf.size() > 0) begin
            m_idle = m_idle + 1;
            if (m_idle == TO_CYC) m_phase = 3;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("we",      32'(o_mem_we), 32'(exp_we));
        check("loading", 32'(o_loading), 32'(m_phase == 1));
        check("done",    32'(o_done),    32'(m_phase == 2));
        check("error",   32'(o_error),   32'(m_phase == 3));
        check("count",   32'(o_word_count), 32'(m_count));
        check("addr",    32'(o_mem_addr),   32'(exp_addr));
        check("wdata",   o_mem_wdata,       exp_wdata);
        if (o_mem_we === 1'b1) we_seen = we_seen + 1;
    endtask

    // One clock of stimulus, then per-cycle comparison on the falling edge
    task automatic drv(input logic rs, input logic st, input logic v, input logic [7:0] d);
        i_reset    = rs;
        i_start    = st;
        i_rx_valid = v;
        i_rx_data  = d;
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) drv(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w);
        drv(1'b0, 1'b0, 1'b1, w[31:24]);
        drv(1'b0, 1'b0, 1'b1, w[23:16]);
        drv(1'b0, 1'b0, 1'b1, w[15:8]);
        drv(1'b0, 1'b0, 1'b1, w[7:0]);
    endtask

    initial begin
        int base;
        int mode;
        int len;
        logic rs, st, v;
        logic [7:0] d;

        total      = 0;
        bad        = 0;
        we_seen    = 0;
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;

        // Reset state
        drv(1'b1, 1'b0, 1'b0, 8'h00);
        drv(1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_we",    32'(o_mem_we), 32'd0);
        check("rst_flags", {29'd0, o_loading, o_done, o_error}, 32'd0);
        check("rst_count", 32'(o_word_count), 32'd0);

        // Bytes presented while idle are dropped
        for (int k = 0; k < 4; k++) drv(1'b0, 1'b0, 1'b1, 8'h12);
        check("idle_count", 32'(o_word_count), 32'd0);
        check("idle_load",  32'(o_loading), 32'd0);

        // Normal load ending in HALT
        drv(1'b0, 1'b1, 1'b0, 8'h00);
        check("start_load", 32'(o_loading), 32'd1);
        send_word(32'h8C010001);
        check("w0_we",   32'(o_mem_we), 32'd1);
        check("w0_addr", 32'(o_mem_addr), 32'd0);
        check("w0_data", o_mem_wdata, 32'h8C010001);
        send_word(32'h8C020002);
        check("w1_addr", 32'(o_mem_addr), 32'd1);
        send_word(32'h80000000);
        check("w2_addr", 32'(o_mem_addr), 32'd2);
        check("w2_data", o_mem_wdata, 32'h80000000);
        send_word(32'hFC000000);
        check("halt_addr", 32'(o_mem_addr), 32'd3);
        check("halt_data", o_mem_wdata, 32'hFC000000);
        check("halt_done", 32'(o_done), 32'd1);
        check("halt_load", 32'(o_loading), 32'd0);
        check("halt_cnt",  32'(o_word_count), 32'd4);
        check("model_cnt", 32'(m_count), 32'd4);
        drv(1'b0, 1'b0, 1'b1, 8'h55);
        check("done_no_we", 32'(o_mem_we), 32'd0);

        // Restart from DONE, then two words at full byte rate
        drv(1'b0, 1'b1, 1'b0, 8'h00);
        check("rs_done", 32'(o_done), 32'd0);
        check("rs_cnt",  32'(o_word_count), 32'd0);
        base = we_seen;
        send_word(32'h11223344);
        check("b2b0_addr", 32'(o_mem_addr), 32'd0);
        check("b2b0_data", o_mem_wdata, 32'h11223344);
        send_word(32'h55667788);
        check("b2b1_we",   32'(o_mem_we), 32'd1);
        check("b2b1_addr", 32'(o_mem_addr), 32'd1);
        check("b2b1_data", o_mem_wdata, 32'h55667788);
        check("b2b_pulses", 32'(we_seen - base), 32'd2);

        // Reset in the middle of a word, then a fresh load
        drv(1'b0, 1'b0, 1'b1, 8'hDE);
        drv(1'b0, 1'b0, 1'b1, 8'hAD);
        drv(1'b1, 1'b0, 1'b1, 8'hBE);
        check("mid_rst_flags", {29'd0, o_loading, o_done, o_error}, 32'd0);
        check("mid_rst_cnt",   32'(o_word_count), 32'd0);
        check("mid_rst_data",  o_mem_wdata, 32'd0);
        drv(1'b0, 1'b1, 1'b0, 8'h00);
        send_word(32'hA1B2C3D4);
        check("after_rst_addr", 32'(o_mem_addr), 32'd0);
        check("after_rst_data", o_mem_wdata, 32'hA1B2C3D4);

        // Inter-byte timeout
        drv(1'b1, 1'b0, 1'b0, 8'h00);
        drv(1'b0, 1'b1, 1'b0, 8'h00);
        base = we_seen;
        drv(1'b0, 1'b0, 1'b1, 8'hAA);
        drv(1'b0, 1'b0, 1'b1, 8'hBB);
        idle_n(TO_CYC - 1);
        check("to_early", 32'(o_error), 32'd0);
        idle_n(1);
        check("to_err",    32'(o_error), 32'd1);
        check("to_no_we",  32'(we_seen - base), 32'd0);
        check("to_cnt",    32'(o_word_count), 32'd0);

        // Overflow: 128 non-HALT words, restart from ERROR
        drv(1'b0, 1'b1, 1'b0, 8'h00);
        base = we_seen;
        for (int k = 0; k < 128; k++) send_word(32'(k));
        check("ovf_last_addr", 32'(o_mem_addr), 32'd127);
        check("ovf_err",    32'(o_error), 32'd1);
        check("ovf_cnt",    32'(o_word_count), 32'd128);
        check("ovf_pulses", 32'(we_seen - base), 32'd128);
        send_word(32'h01020304);
        check("ovf_after",  32'(we_seen - base), 32'd128);

        // Random traffic: bursty, moderate and sparse byte rates
        for (int s = 0; s < 70; s++) begin
            mode = int'($urandom_range(0, 2));
            len  = int'($urandom_range(20, 120));
            for (int c = 0; c < len; c++) begin
                rs = ($urandom_range(0, 399) == 0);
                st = ($urandom_range(0, 29) == 0);
                case (mode)
                    0:       v = 1'b1;
                    1:       v = ($urandom_range(0, 3) != 0);
                    default: v = ($urandom_range(0, 19) == 0);
                endcase
                d = 8'($urandom);
                if ($urandom_range(0, 24) == 0) d = 8'hFC;
                drv(rs, st, v, d);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
